// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use and branch-operand hazard detection with stall/flush counters
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_branch,
  input  logic        id_redirect,
  input  logic        ex_memread,
  input  logic        ex_regwrite,
  input  logic [4:0]  ex_dst,
  input  logic        mem_memread,
  input  logic [4:0]  mem_dst,
  output logic        pc_write,
  output logic        hazard,
  output logic        branch_bubble,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic {RUN = 1'b0, BR_WAIT = 1'b1} state_t;

  state_t state;
  state_t state_next;

  logic ex_match;
  logic mem_match;
  logic cond_lu;
  logic cond_br1;
  logic cond_br2;
  logic cond_brm;
  logic any_stall;

  // Register 0 is hard-wired zero, so it can never carry a true dependency.
  function automatic logic src_match(input logic [4:0] dst,
                                     input logic [4:0] rs, input logic use_rs,
                                     input logic [4:0] rt, input logic use_rt);
    return (dst != 5'd0) && ((use_rs && (rs == dst)) || (use_rt && (rt == dst)));
  endfunction

  assign ex_match  = src_match(ex_dst,  id_rs, id_use_rs, id_rt, id_use_rt);
  assign mem_match = src_match(mem_dst, id_rs, id_use_rs, id_rt, id_use_rt);

  assign cond_lu  = ex_memread && ex_match && !id_branch;
  assign cond_br1 = id_branch && ex_regwrite && !ex_memread && ex_match;
  assign cond_br2 = id_branch && ex_memread && ex_match;
  assign cond_brm = id_branch && mem_memread && mem_match;

  always_comb begin
    pc_write      = 1'b1;
    hazard        = 1'b0;
    branch_bubble = 1'b0;
    idex_bubble   = 1'b0;
    state_next    = RUN;
    if (rst) begin
      pc_write = 1'b0;
    end else if (state == BR_WAIT) begin
      branch_bubble = 1'b1;
      pc_write      = 1'b0;
      idex_bubble   = 1'b1;
    end else if (cond_br1 || cond_br2 || cond_brm) begin
      // Branch conditions win over load-use; cond_lu already excludes branches.
      branch_bubble = 1'b1;
      pc_write      = 1'b0;
      idex_bubble   = 1'b1;
      if (cond_br2) state_next = BR_WAIT;
    end else if (cond_lu) begin
      hazard      = 1'b1;
      pc_write    = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  assign any_stall  = hazard || branch_bubble || idex_bubble || !pc_write;
  assign ifid_flush = !rst && id_redirect && !any_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      state <= state_next;
      if (!pc_write && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (ifid_flush && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_dst, mem_dst;
  logic        id_use_rs, id_use_rt, id_branch, id_redirect;
  logic        ex_memread, ex_regwrite, mem_memread;
  logic        pc_write, hazard, branch_bubble, idex_bubble, ifid_flush;
  logic [15:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_branch(id_branch), .id_redirect(id_redirect),
    .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_dst(ex_dst),
    .mem_memread(mem_memread), .mem_dst(mem_dst),
    .pc_write(pc_write), .hazard(hazard), .branch_bubble(branch_bubble),
    .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ctl(input string tag, input logic pw, input logic hz, input logic bb,
                     input logic ib, input logic fl);
    check({tag, ".pc_write"},      {15'd0, pc_write},      {15'd0, pw});
    check({tag, ".hazard"},        {15'd0, hazard},        {15'd0, hz});
    check({tag, ".branch_bubble"}, {15'd0, branch_bubble}, {15'd0, bb});
    check({tag, ".idex_bubble"},   {15'd0, idex_bubble},   {15'd0, ib});
    check({tag, ".ifid_flush"},    {15'd0, ifid_flush},    {15'd0, fl});
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_branch = 0; id_redirect = 0;
    ex_memread = 0; ex_regwrite = 0; ex_dst = 0; mem_memread = 0; mem_dst = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    #1;
    ctl("reset", 0, 0, 0, 0, 0);
    check("reset.stall_cnt", stall_cnt, 16'd0);
    check("reset.flush_cnt", flush_cnt, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    ctl("idle", 1, 0, 0, 0, 0);

    // load-use on rs
    ex_memread = 1; ex_dst = 5; id_rs = 5; id_use_rs = 1;
    #1 ctl("lu", 0, 1, 0, 1, 0);
    tick();
    check("lu.stall_cnt", stall_cnt, 16'd1);
    ex_memread = 0; ex_dst = 0;
    #1 ctl("lu_after", 1, 0, 0, 0, 0);
    tick();
    check("lu_after.stall_cnt", stall_cnt, 16'd1);

    // register 0 never matches
    clear_inputs();
    ex_memread = 1; ex_dst = 0; id_rs = 0; id_use_rs = 1;
    #1 ctl("zero_reg", 1, 0, 0, 0, 0);
    tick();
    check("zero_reg.stall_cnt", stall_cnt, 16'd1);

    // rt matches but is not read
    clear_inputs();
    ex_memread = 1; ex_dst = 5; id_rt = 5; id_use_rt = 0;
    #1 ctl("unused_rt", 1, 0, 0, 0, 0);

    // ALU result feeding a non-branch is forwarded, no stall
    clear_inputs();
    ex_regwrite = 1; ex_dst = 4; id_rs = 4; id_use_rs = 1;
    #1 ctl("alu_fwd", 1, 0, 0, 0, 0);
    tick();

    // branch after load: two stall cycles
    clear_inputs();
    id_branch = 1; id_rt = 7; id_use_rt = 1; ex_memread = 1; ex_regwrite = 1; ex_dst = 7;
    #1 ctl("br2_c1", 0, 0, 1, 1, 0);
    tick();
    check("br2_c1.stall_cnt", stall_cnt, 16'd2);
    ex_memread = 0; ex_regwrite = 0; ex_dst = 0; mem_memread = 1; mem_dst = 7;
    #1 ctl("br2_c2", 0, 0, 1, 1, 0);
    tick();
    check("br2_c2.stall_cnt", stall_cnt, 16'd3);
    mem_memread = 0; mem_dst = 0;
    #1 ctl("br2_done", 1, 0, 0, 0, 0);
    tick();
    check("br2_done.stall_cnt", stall_cnt, 16'd3);

    // branch after ALU op with redirect held
    clear_inputs();
    id_branch = 1; id_rs = 3; id_use_rs = 1; ex_regwrite = 1; ex_dst = 3; id_redirect = 1;
    #1 ctl("br1_redir", 0, 0, 1, 1, 0);
    tick();
    check("br1_redir.stall_cnt", stall_cnt, 16'd4);
    check("br1_redir.flush_cnt", flush_cnt, 16'd0);
    ex_regwrite = 0; ex_dst = 0;
    #1 ctl("redir_go", 1, 0, 0, 0, 1);
    tick();
    check("redir_go.flush_cnt", flush_cnt, 16'd1);
    check("redir_go.stall_cnt", stall_cnt, 16'd4);

    // branch with load in MEM: one cycle only, stays in RUN
    clear_inputs();
    id_branch = 1; id_rs = 9; id_use_rs = 1; mem_memread = 1; mem_dst = 9;
    #1 ctl("brm", 0, 0, 1, 1, 0);
    tick();
    check("brm.stall_cnt", stall_cnt, 16'd5);
    mem_memread = 0; mem_dst = 0;
    #1 ctl("brm_done", 1, 0, 0, 0, 0);

    // reset pulsed between edges while in BR_WAIT
    clear_inputs();
    id_branch = 1; id_rt = 7; id_use_rt = 1; ex_memread = 1; ex_dst = 7;
    tick();
    check("rst_mid.stall_pre", stall_cnt, 16'd6);
    clear_inputs();
    #1 ctl("br_wait", 0, 0, 1, 1, 0);
    #1 rst = 1'b1;
    #1 ctl("rst_mid", 0, 0, 0, 0, 0);
    check("rst_mid.stall_cnt", stall_cnt, 16'd0);
    check("rst_mid.flush_cnt", flush_cnt, 16'd0);
    #1 rst = 1'b0;
    #1 ctl("rst_release", 1, 0, 0, 0, 0);

    // saturation: 65535 stall cycles then one more
    ex_memread = 1; ex_dst = 5; id_rs = 5; id_use_rs = 1;
    repeat (65535) @(posedge clk);
    #1;
    check("sat.stall_cnt", stall_cnt, 16'hFFFF);
    tick();
    check("sat_hold.stall_cnt", stall_cnt, 16'hFFFF);
    check("sat_hold.flush_cnt", flush_cnt, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
